// File: rtl/plru_array.sv
// Tree-PLRU replacement state for an N-way, M-set cache. Victim lookups have one cycle of latency, and a sequencer clears one set per cycle on flush.
// Optional PLRU_INVALID_FIRST_EN: a lookup picks the lowest-index invalid way ahead of the PLRU walk.
module plru_array #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        flush_i,
  output logic                        busy_o,
  input  logic                        lookup_valid_i,
  input  logic [$clog2(NUM_SETS)-1:0] lookup_set_i,
  input  logic [NUM_WAYS-1:0]         lookup_way_valid_i,
  output logic                        victim_valid_o,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way_o,
  input  logic                        touch_valid_i,
  input  logic [$clog2(NUM_SETS)-1:0] touch_set_i,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way_i
);

  localparam int AGE_WIDTH = NUM_WAYS - 1;
  localparam int WAY_WIDTH = $clog2(NUM_WAYS);
  localparam int SET_WIDTH = $clog2(NUM_SETS);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state;
  logic [SET_WIDTH-1:0]   flush_cnt;
  logic [AGE_WIDTH-1:0]   age [NUM_SETS];
  logic [AGE_WIDTH-1:0]   lookup_bits;
  logic [AGE_WIDTH-1:0]   touch_bits;
  logic [WAY_WIDTH-1:0]   victim_next;

  // Node bits along the path point away from the touched way.
  function automatic logic [AGE_WIDTH-1:0] apply_touch(input logic [AGE_WIDTH-1:0] bits,
                                                       input logic [WAY_WIDTH-1:0] way);
    logic [AGE_WIDTH-1:0] res;
    int node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      res[node] = ~way[WAY_WIDTH-1-l];
      node      = way[WAY_WIDTH-1-l] ? 2*node + 2 : 2*node + 1;
    end
    return res;
  endfunction

  function automatic logic [WAY_WIDTH-1:0] victim_walk(input logic [AGE_WIDTH-1:0] bits);
    logic [WAY_WIDTH-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_WIDTH; l++) begin
      way[WAY_WIDTH-1-l] = bits[node];
      node               = bits[node] ? 2*node + 2 : 2*node + 1;
    end
    return way;
  endfunction

  assign touch_bits = apply_touch(age[touch_set_i], touch_way_i);

  // A touch to the queried set in the same cycle is forwarded into the walk.
  always_comb begin
    lookup_bits = age[lookup_set_i];
    if (touch_valid_i && (touch_set_i == lookup_set_i))
      lookup_bits = apply_touch(lookup_bits, touch_way_i);
  end

`ifdef PLRU_INVALID_FIRST_EN
  always_comb begin
    victim_next = victim_walk(lookup_bits);
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!lookup_way_valid_i[i]) victim_next = WAY_WIDTH'(i);
  end
`else
  assign victim_next = victim_walk(lookup_bits);
  logic unused_mask;
  assign unused_mask = &{1'b0, lookup_way_valid_i};
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < NUM_SETS; s++) age[s] <= '0;
    end else if (state == FLUSH) begin
      age[flush_cnt] <= '0;
    end else if (touch_valid_i) begin
      age[touch_set_i] <= touch_bits;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      busy_o         <= 1'b0;
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else begin
      victim_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (lookup_valid_i) begin
            victim_valid_o <= 1'b1;
            victim_way_o   <= victim_next;
          end
          if (flush_i) begin
            state     <= FLUSH;
            busy_o    <= 1'b1;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_i) begin
            flush_cnt <= '0;
          end else if (flush_cnt == SET_WIDTH'(NUM_SETS - 1)) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + SET_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_array.sv
// Randomized and directed bench for plru_array against a heap-arithmetic PLRU model.
module tb_plru_array;
  localparam int NW = 4;
  localparam int NS = 64;
  localparam int AW = NW - 1;
  localparam int WW = 2;
  localparam int SW = 6;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          flush_i;
  logic          busy_o;
  logic          lookup_valid_i;
  logic [SW-1:0] lookup_set_i;
  logic [NW-1:0] lookup_way_valid_i;
  logic          victim_valid_o;
  logic [WW-1:0] victim_way_o;
  logic          touch_valid_i;
  logic [SW-1:0] touch_set_i;
  logic [WW-1:0] touch_way_i;

  plru_array #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .busy_o(busy_o),
    .lookup_valid_i(lookup_valid_i), .lookup_set_i(lookup_set_i),
    .lookup_way_valid_i(lookup_way_valid_i), .victim_valid_o(victim_valid_o),
    .victim_way_o(victim_way_o), .touch_valid_i(touch_valid_i),
    .touch_set_i(touch_set_i), .touch_way_i(touch_way_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] mbits [NS];
  int            busy_left;
  logic [WW-1:0] mlast;
  int            n;
  int            r_set, r_tset, r_tway;
  logic          r_lv, r_tv;
  logic [NW-1:0] r_mask;

  // Model: the node at depth l on the path to way w is (2^l - 1) + (w >> (WW - l)).
  function automatic logic [AW-1:0] m_touch(input logic [AW-1:0] b, input int w);
    logic [AW-1:0] r;
    r = b;
    for (int l = 0; l < WW; l++)
      r[(1 << l) - 1 + (w >> (WW - l))] = (((w >> (WW - 1 - l)) & 1) == 0);
    return r;
  endfunction

  function automatic logic [WW-1:0] m_victim(input logic [AW-1:0] b);
    int w;
    w = 0;
    for (int l = 0; l < WW; l++)
      w = 2 * w + int'(b[(1 << l) - 1 + w]);
    return WW'(w);
  endfunction

  function automatic logic [WW-1:0] m_pick(input logic [AW-1:0] b, input logic [NW-1:0] mask);
`ifdef PLRU_INVALID_FIRST_EN
    for (int i = 0; i < NW; i++)
      if (!mask[i]) return WW'(i);
`endif
    return m_victim(b);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic lv, input int lset, input logic [NW-1:0] lmask,
                       input logic tv, input int tset, input int tway, input logic fl);
    logic          exp_v;
    logic [WW-1:0] exp_w;
    logic [AW-1:0] b;
    lookup_valid_i     = lv;
    lookup_set_i       = SW'(lset);
    lookup_way_valid_i = lmask;
    touch_valid_i      = tv;
    touch_set_i        = SW'(tset);
    touch_way_i        = WW'(tway);
    flush_i            = fl;
    exp_v = lv && (busy_left == 0);
    b = mbits[lset];
    if (tv && (tset == lset)) b = m_touch(b, tway);
    exp_w = exp_v ? m_pick(b, lmask) : mlast;
    @(posedge clk_i);
    #1;
    if (busy_left > 0) begin
      mbits[NS - busy_left] = '0;
      busy_left = fl ? NS : busy_left - 1;
    end else begin
      if (tv) mbits[tset] = m_touch(mbits[tset], tway);
      if (fl) busy_left = NS;
    end
    mlast = exp_w;
    if (exp_v) $display("lookup set %0d mask %b -> way %0d (dut %0d)", lset, lmask, exp_w, victim_way_o);
    check("victim_valid", 32'(victim_valid_o), 32'(exp_v));
    check("victim_way", 32'(victim_way_o), 32'(exp_w));
    check("busy", 32'(busy_o), 32'(busy_left > 0));
  endtask

  task automatic idle();
    cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic rand_cycle(input logic allow_flush);
    r_lv   = 1'($urandom_range(0, 1));
    r_set  = $urandom_range(0, 7);
    r_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
    r_tv   = 1'($urandom_range(0, 1));
    r_tset = $urandom_range(0, 7);
    r_tway = $urandom_range(0, NW - 1);
    cycle(r_lv, r_set, r_mask, r_tv, r_tset, r_tway, allow_flush && ($urandom_range(0, 199) == 0));
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; lookup_valid_i = 1'b0; lookup_set_i = '0;
    lookup_way_valid_i = '1; touch_valid_i = 1'b0; touch_set_i = '0; touch_way_i = '0;
    for (int s = 0; s < NS; s++) mbits[s] = '0;
    busy_left = 0;
    mlast = '0;
    #12;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_vvalid", 32'(victim_valid_o), 32'd0);
    check("reset_vway", 32'(victim_way_o), 32'd0);
    #10 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Set 5 walk sequence from reset.
    cycle(1'b1, 5, 4'hF, 1'b0, 0, 0, 1'b0); check("seq_way0", 32'(victim_way_o), 32'd0);
    cycle(1'b0, 0, 4'hF, 1'b1, 5, 0, 1'b0);
    cycle(1'b1, 5, 4'hF, 1'b0, 0, 0, 1'b0); check("seq_way2", 32'(victim_way_o), 32'd2);
    cycle(1'b0, 0, 4'hF, 1'b1, 5, 2, 1'b0);
    cycle(1'b1, 5, 4'hF, 1'b0, 0, 0, 1'b0); check("seq_way1", 32'(victim_way_o), 32'd1);
    cycle(1'b0, 0, 4'hF, 1'b1, 5, 1, 1'b0);
    cycle(1'b1, 5, 4'hF, 1'b0, 0, 0, 1'b0); check("seq_way3", 32'(victim_way_o), 32'd3);

    // Same-cycle forwarding, and independence of a different set.
    cycle(1'b1, 3, 4'hF, 1'b1, 3, 0, 1'b0); check("fwd_same_set", 32'(victim_way_o), 32'd2);
    cycle(1'b1, 4, 4'hF, 1'b1, 3, 0, 1'b0); check("fwd_other_set", 32'(victim_way_o), 32'd0);

`ifdef PLRU_INVALID_FIRST_EN
    cycle(1'b0, 0, 4'hF, 1'b1, 7, 0, 1'b0);
    cycle(1'b1, 7, 4'b1011, 1'b0, 0, 0, 1'b0); check("inv_1011", 32'(victim_way_o), 32'd2);
    cycle(1'b1, 7, 4'b1111, 1'b0, 0, 0, 1'b0); check("inv_1111", 32'(victim_way_o), 32'd2);
    cycle(1'b1, 7, 4'b0110, 1'b0, 0, 0, 1'b0); check("inv_0110", 32'(victim_way_o), 32'd0);
`else
    cycle(1'b1, 5, 4'b1011, 1'b0, 0, 0, 1'b0); check("mask_ignored", 32'(victim_way_o), 32'd3);
`endif

    for (int i = 0; i < 400; i++) rand_cycle(1'b0);

    // Flush: busy exactly NS cycles, lookups ignored, all sets cleared.
    cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b1);
    n = 0;
    while (busy_o && n < 300) begin
      n++;
      cycle(1'b1, $urandom_range(0, NS - 1), 4'hF, 1'b1, $urandom_range(0, 7), $urandom_range(0, NW - 1), 1'b0);
    end
    check("flush_len", 32'(n), 32'd64);
    for (int s = 0; s < NS; s++) begin
      cycle(1'b1, s, 4'hF, 1'b0, 0, 0, 1'b0);
      check("post_flush_way", 32'(victim_way_o), 32'd0);
    end

    // Re-flush at busy cycle 30 extends busy.
    for (int i = 0; i < 50; i++) rand_cycle(1'b0);
    cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b1);
    n = 0;
    while (busy_o && n < 300) begin
      n++;
      cycle(1'b1, $urandom_range(0, 7), 4'hF, 1'b0, 0, 0, n == 30);
    end
    check("reflush_len", 32'(n), 32'd94);

    for (int i = 0; i < 200; i++) rand_cycle(1'b1);
    while (busy_left > 0) idle();

    // Asynchronous reset in the middle of a flush.
    cycle(1'b0, 0, 4'hF, 1'b1, 63, 0, 1'b0);
    cycle(1'b0, 0, 4'hF, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) idle();
    rstn_i = 1'b0;
    #1;
    check("midflush_busy", 32'(busy_o), 32'd0);
    check("midflush_vvalid", 32'(victim_valid_o), 32'd0);
    check("midflush_vway", 32'(victim_way_o), 32'd0);
    for (int s = 0; s < NS; s++) mbits[s] = '0;
    busy_left = 0;
    mlast = '0;
    #3 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    cycle(1'b1, 63, 4'hF, 1'b0, 0, 0, 1'b0);
    check("after_reset_way", 32'(victim_way_o), 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
